spio_spinnaker_link_tx_ack_ctrl: RTL and testbench

Transmit-side flow controller for a SpiNNaker link. It accepts 2-of-7 transition masks from the packet serialiser and drives the 7 NRZ data wires. It holds off the next symbol until the remote end toggles the acknowledge wire. The asynchronous acknowledge is brought into the clock domain through an internal 2-flop synchroniser, and a timeout recovers from a lost acknowledge.

---
 rtl/spio_spinnaker_link_pkg.sv | 23 ++
 rtl/spio_spinnaker_link_sync2.sv | 36 +++
 rtl/spio_spinnaker_link_tx_ack_ctrl.sv | 119 +++++++++++
 tb/tb_spio_spinnaker_link_tx_ack_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/spio_spinnaker_link_pkg.sv
// Shared definitions for the SpiNNaker link transmit path: state encoding,
// link width and the 2-of-7 symbol validity check.
package spio_spinnaker_link_pkg;

    localparam int SL_WIDTH = 7;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_IDLE     = 2'd1,
        ST_WAIT_ACK = 2'd2
    } sl_tx_state_t;

    // A symbol is legal only when exactly two of the seven wires transition.
    function automatic logic sl_sym_is_valid(input logic [SL_WIDTH-1:0] sym);
        int unsigned ones;
        ones = 0;
        for (int i = 0; i < SL_WIDTH; i++) begin
            ones += {31'd0, sym[i]};
        end
        return (ones == 2);
    endfunction

endpackage

// File: rtl/spio_spinnaker_link_sync2.sv
// Two-flop synchroniser. Each stage has its own clock pin so the cell can sit
// on a domain boundary; inside a single domain both pins share one clock.
module spio_spinnaker_link_sync2 #(
    parameter int SIZE = 1
) (
    input  logic            CLK0_IN,
    input  logic            CLK1_IN,
    input  logic            RESET_IN,
    input  logic [SIZE-1:0] DATA_IN,
    output logic [SIZE-1:0] DATA_OUT
);

    logic [SIZE-1:0] meta_q;
    logic [SIZE-1:0] sync_q;

    // First stage: capture the asynchronous input, may go metastable.
    always_ff @(posedge CLK0_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            meta_q <= '0;
        end else begin
            meta_q <= DATA_IN;
        end
    end

    // Second stage: give the first stage a full cycle to resolve.
    always_ff @(posedge CLK1_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            sync_q <= '0;
        end else begin
            sync_q <= meta_q;
        end
    end

    assign DATA_OUT = sync_q;

endmodule

// File: rtl/spio_spinnaker_link_tx_ack_ctrl.sv
// SpiNNaker link transmit flow control: applies 2-of-7 transition masks to
// the NRZ data wires and holds off the next symbol until the remote end
// toggles the acknowledge wire, with a timeout for a lost acknowledge.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   ST_INIT     | after reset; lets the synchroniser fill, then goes idle
//   ST_IDLE     | ready for a symbol; ack edges here are spurious, ignored
//   ST_WAIT_ACK | symbol on the wires; waiting for ack edge or timeout
module spio_spinnaker_link_tx_ack_ctrl
    import spio_spinnaker_link_pkg::*;
#(
    parameter int TIMEOUT = 512
) (
    input  logic                CLK_IN,
    input  logic                RESET_IN,
    input  logic [SL_WIDTH-1:0] SYM_IN,
    input  logic                SYM_VLD_IN,
    output logic                SYM_RDY_OUT,
    input  logic                SL_ACK_IN,
    output logic [SL_WIDTH-1:0] SL_DATA_OUT,
    output logic                TIMEOUT_OUT,
    output logic                ERR_OUT
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    sl_tx_state_t        state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                ack_last_q;
    logic [SL_WIDTH-1:0] data_q;
    logic                timeout_q;
    logic                err_q;

    logic                ack_s;
    logic                ack_edge;

    spio_spinnaker_link_sync2 #(
        .SIZE (1)
    ) u_ack_sync (
        .CLK0_IN  (CLK_IN),
        .CLK1_IN  (CLK_IN),
        .RESET_IN (RESET_IN),
        .DATA_IN  (SL_ACK_IN),
        .DATA_OUT (ack_s)
    );

    // Acknowledge is transition-signalled: any change from the baseline counts.
    assign ack_edge = ack_s ^ ack_last_q;

    // Sequencer: symbol acceptance, ack/timeout tracking and registered outputs.
    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            ack_last_q <= 1'b0;
            data_q     <= '0;
            timeout_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // Baseline always tracks the synchronised ack, so a spurious edge
            // in IDLE is absorbed without further effect.
            ack_last_q <= ack_s;
            timeout_q  <= 1'b0;
            err_q      <= 1'b0;

            case (state_q)
                ST_INIT: begin
                    // One cycle for the synchroniser to load, one to capture
                    // the baseline, then become ready.
                    if (cnt_q == '0) begin
                        cnt_q <= CNT_W'(1);
                    end else begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end
                end

                ST_IDLE: begin
                    if (SYM_VLD_IN) begin
                        if (sl_sym_is_valid(SYM_IN)) begin
                            data_q  <= data_q ^ SYM_IN;
                            cnt_q   <= '0;
                            state_q <= ST_WAIT_ACK;
                        end else begin
                            // Illegal mask would corrupt the NRZ code; drop it.
                            err_q <= 1'b1;
                        end
                    end
                end

                ST_WAIT_ACK: begin
                    // Ack takes priority so a late-but-valid ack is never
                    // reported as a timeout.
                    if (ack_edge) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        timeout_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                default: begin
                    state_q <= ST_INIT;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign SYM_RDY_OUT = (state_q == ST_IDLE);
    assign SL_DATA_OUT = data_q;
    assign TIMEOUT_OUT = timeout_q;
    assign ERR_OUT     = err_q;

endmodule

// File: tb/tb_spio_spinnaker_link_tx_ack_ctrl.sv
module tb_spio_spinnaker_link_tx_ack_ctrl;

    localparam int TO = 16;

    logic       clk;
    logic       rst;
    logic [6:0] sym;
    logic       sym_vld;
    logic       sym_rdy;
    logic       ack;
    logic [6:0] sl_data;
    logic       tmo;
    logic       err;

    int n_vec;
    int n_miss;
    logic [6:0] exp_data;

    spio_spinnaker_link_tx_ack_ctrl #(
        .TIMEOUT (TO)
    ) dut (
        .CLK_IN      (clk),
        .RESET_IN    (rst),
        .SYM_IN      (sym),
        .SYM_VLD_IN  (sym_vld),
        .SYM_RDY_OUT (sym_rdy),
        .SL_ACK_IN   (ack),
        .SL_DATA_OUT (sl_data),
        .TIMEOUT_OUT (tmo),
        .ERR_OUT     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [6:0] s);
        sym     = s;
        sym_vld = 1'b1;
        tick();
        sym_vld = 1'b0;
    endtask

    initial begin
        n_vec    = 0;
        n_miss   = 0;
        rst      = 1'b1;
        sym      = '0;
        sym_vld  = 1'b0;
        ack      = 1'b0;
        exp_data = '0;

        // Reset held across edges
        tick();
        tick();
        chk_eq("rst_data", sl_data, 7'd0);
        chk_eq("rst_rdy",  sym_rdy, 1'b0);
        chk_eq("rst_tmo",  tmo,     1'b0);
        chk_eq("rst_err",  err,     1'b0);

        rst = 1'b0;
        tick();
        chk_eq("rel_edge1_rdy", sym_rdy, 1'b0);
        tick();
        chk_eq("rel_edge2_rdy", sym_rdy, 1'b1);

        // First valid symbol, then ack latency
        send(7'b0000011);
        exp_data = 7'b0000011;
        chk_eq("s1_data", sl_data, exp_data);
        chk_eq("s1_rdy",  sym_rdy, 1'b0);
        ack = ~ack;
        tick();
        chk_eq("ack_e1_rdy", sym_rdy, 1'b0);
        tick();
        chk_eq("ack_e2_rdy", sym_rdy, 1'b0);
        tick();
        chk_eq("ack_e3_rdy", sym_rdy, 1'b1);

        // Back-to-back symbol accumulates onto the NRZ wires
        send(7'b0010100);
        exp_data = 7'b0010111;
        chk_eq("s2_data", sl_data, exp_data);
        chk_eq("s2_rdy",  sym_rdy, 1'b0);
        ack = ~ack;
        repeat (3) tick();
        chk_eq("s2_ack_rdy", sym_rdy, 1'b1);

        // Timeout with no acknowledge
        send(7'b1000001);
        exp_data = 7'b1010110;
        chk_eq("to_data", sl_data, exp_data);
        for (int i = 1; i < TO; i++) begin
            tick();
            chk_eq("to_early_tmo", tmo, 1'b0);
            chk_eq("to_early_rdy", sym_rdy, 1'b0);
        end
        tick();
        chk_eq("to_pulse_tmo", tmo,     1'b1);
        chk_eq("to_pulse_rdy", sym_rdy, 1'b1);
        chk_eq("to_keep_data", sl_data, exp_data);
        tick();
        chk_eq("to_after_tmo", tmo, 1'b0);

        // Acknowledge seen on the same edge the timeout would fire
        send(7'b0011000);
        exp_data = 7'b1001110;
        chk_eq("race_data", sl_data, exp_data);
        repeat (TO - 3) tick();
        ack = ~ack;
        tick();
        tick();
        chk_eq("race_pre_rdy", sym_rdy, 1'b0);
        tick();
        chk_eq("race_tmo", tmo,     1'b0);
        chk_eq("race_rdy", sym_rdy, 1'b1);
        tick();
        chk_eq("race_after_tmo", tmo, 1'b0);

        // Invalid mask dropped with an error pulse
        send(7'b0000111);
        chk_eq("bad_err",  err,     1'b1);
        chk_eq("bad_data", sl_data, exp_data);
        chk_eq("bad_rdy",  sym_rdy, 1'b1);
        tick();
        chk_eq("bad_err_clr", err, 1'b0);

        // Spurious ack in IDLE
        ack = ~ack;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_eq("spur_rdy",  sym_rdy, 1'b1);
            chk_eq("spur_data", sl_data, exp_data);
            chk_eq("spur_tmo",  tmo,     1'b0);
            chk_eq("spur_err",  err,     1'b0);
        end

        // Reset in the middle of WAIT_ACK, between edges
        send(7'b0100001);
        exp_data = 7'b1101111;
        chk_eq("mid_data", sl_data, exp_data);
        chk_eq("mid_rdy",  sym_rdy, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_eq("mid_rst_data", sl_data, 7'd0);
        chk_eq("mid_rst_rdy",  sym_rdy, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        chk_eq("rel2_edge1_rdy", sym_rdy, 1'b0);
        tick();
        chk_eq("rel2_edge2_rdy", sym_rdy, 1'b1);
        // Baseline may still be settling if ack was high at reset; wait it out.
        repeat (3) tick();
        send(7'b0000110);
        exp_data = 7'b0000110;
        chk_eq("post_data", sl_data, exp_data);
        ack = ~ack;
        repeat (3) tick();
        chk_eq("post_ack_rdy", sym_rdy, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
